// File: rtl/imem_access_arbiter_if.sv
// Bundle of the fetch, loader and memory-port signals around the instruction-memory arbiter.
// slave = arbiter side, master = requesters plus memory (the bench side).
interface imem_access_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_err;
    logic              load_req;
    logic [31:0]       load_addr;
    logic [DATA_W-1:0] load_wdata;
    logic              load_last;
    logic              load_gnt;
    logic              boot_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_last, mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, load_gnt, boot_done,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_last, mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, load_gnt, boot_done,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_access_arbiter.sv
// Single-port instruction-memory owner: boot-time loader writes, then fetch/loader sharing
// with a starvation bound that guarantees fetch progress.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_BOOT | fetch locked out, every loader beat granted until load_last
//   ST_RUN  | loader has priority, fetch forced through after STARVE_LIMIT
module imem_access_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter bit BOOT_SKIP    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_access_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t     RESET_STATE = BOOT_SKIP ? ST_RUN : ST_BOOT;
    localparam logic [3:0] LIMIT       = 4'(STARVE_LIMIT);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       rvalid_q;
    logic       err_q;
    logic       fetch_bad;
    logic       fetch_gnt;
    logic       load_gnt;
    logic       unused_addr_bits;

    // Upper loader address bits are deliberately ignored; fetch upper bits are range-checked.
    assign unused_addr_bits = ^{bus.load_addr[31:ADDR_W+2], bus.load_addr[1:0]};

    assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) ||
                       (bus.fetch_addr[31:ADDR_W+2] != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RESET_STATE;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rvalid_q <= fetch_gnt;
            err_q    <= fetch_gnt && fetch_bad;
        end
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        fetch_gnt     = 1'b0;
        load_gnt      = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        if (rst_n) begin
            case (state_q)
                ST_BOOT: begin
                    load_gnt = bus.load_req;
                    if (load_gnt && bus.load_last) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.load_req && bus.fetch_req) begin
                        fetch_gnt = (starve_q == LIMIT);
                        load_gnt  = !fetch_gnt;
                    end else begin
                        load_gnt  = bus.load_req;
                        fetch_gnt = bus.fetch_req;
                    end
                end
                default: state_d = RESET_STATE;
            endcase

            // Count only loader wins that actually kept a waiting fetch out.
            if (!bus.fetch_req || fetch_gnt) begin
                starve_d = '0;
            end else if (load_gnt && (starve_q != LIMIT)) begin
                starve_d = starve_q + 4'd1;
            end

            if (load_gnt) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.load_addr[ADDR_W+1:2];
                bus.mem_wdata = bus.load_wdata;
            end else if (fetch_gnt && !fetch_bad) begin
                bus.mem_en    = 1'b1;
                bus.mem_addr  = bus.fetch_addr[ADDR_W+1:2];
            end
        end
    end

    assign bus.fetch_gnt = fetch_gnt;
    assign bus.load_gnt  = load_gnt;
    assign bus.boot_done = (state_q == ST_RUN);

    // rst_n also masks the response so a reset cycle never exposes a stale beat.
    assign bus.fetch_rvalid = rst_n && rvalid_q;
    assign bus.fetch_err    = rst_n && rvalid_q && err_q;
    assign bus.fetch_rdata  = (rst_n && rvalid_q && !err_q) ? bus.mem_rdata : '0;

endmodule
